// File: rtl/uart_tx.sv
// UART transmitter: one byte per request, 8N1 framing (8E1 when UART_TX_PARITY_EN is defined).
// Bit period is BASE_FREQ / BAUDRATE clock cycles; all outputs are registered.
module uart_tx #(
    parameter int BASE_FREQ = 50_000_000,
    parameter int BAUDRATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] parallel_in,
    output logic       serial_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int COUNTS_PER_BIT = BASE_FREQ / BAUDRATE;
    localparam int CNT_W          = (COUNTS_PER_BIT > 1) ? $clog2(COUNTS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             serial_d, busy_d, done_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // NOTE: every next-state value gets a default before the case so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        serial_d = serial_out;
        busy_d   = tx_busy;
        done_d   = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                if (tx_start) begin
                    shreg_d  = parallel_in;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    idx_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    serial_d = shreg_q[0];
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        serial_d = ^shreg_q;
                        state_d  = PARITY;
`else
                        serial_d = 1'b1;
                        state_d  = STOP;
`endif
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = shreg_q[idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    serial_d = 1'b1;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // Unreachable encodings recover to an idle, high line.
                state_d  = IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            serial_out <= serial_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 10 clocks per bit; the expected line is derived
// from a per-frame bit list (start, data LSB first, optional parity, stop).
module tb_uart_tx;

    localparam int BASE_FREQ = 1_000_000;
    localparam int BAUDRATE  = 100_000;
    localparam int N         = BASE_FREQ / BAUDRATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [7:0] parallel_in;
    logic       serial_out;
    logic       tx_busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .BASE_FREQ(BASE_FREQ),
        .BAUDRATE (BAUDRATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .parallel_in(parallel_in),
        .serial_out (serial_out),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {serial_out, tx_busy, tx_done} against the expected triple.
    task automatic check(input string tag, input int t, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {serial_out, tx_busy, tx_done};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: observed {line,busy,done}=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    // Bit list of one frame, index 0 = start bit, last index = stop bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        b[9] = ^d;
`endif
        return b;
    endfunction

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check(tag, i, 3'b100);
        end
    endtask

    // Issues tx_start with byte d and checks every cycle of the resulting frame.
    // hold keeps tx_start high throughout; poke_at injects a new request with 0xFF
    // mid-frame for one cycle; abort_at applies reset at that cycle and returns.
    task automatic run_frame(input string tag, input logic [7:0] d, input bit hold,
                             input int poke_at, input int abort_at);
        logic [10:0] bits;
        bits = frame_of(d);
        parallel_in = d;
        tx_start    = 1'b1;
        tick();
        if (!hold) tx_start = 1'b0;
        for (int t = 0; t < FRAME_BITS * N; t++) begin
            if (t == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check({tag, "_reset"}, t, 3'b100);
                return;
            end
            check(tag, t, {bits[t / N], 1'b1, 1'b0});
            if (t == poke_at) begin
                parallel_in = 8'hFF;
                tx_start    = 1'b1;
            end else if (!hold) begin
                tx_start = 1'b0;
            end
            tick();
        end
        check({tag, "_done"}, FRAME_BITS * N, 3'b101);
    endtask

    initial begin
        logic [7:0] r;
        rst         = 1'b1;
        tx_start    = 1'b0;
        parallel_in = 8'h00;
        tick();
        tick();
        check("reset", 0, 3'b100);
        rst = 1'b0;
        idle_cycles("idle", 50);

        run_frame("byte55", 8'h55, 1'b0, -1, -1);
        idle_cycles("after55", 5);

        run_frame("byteA3", 8'hA3, 1'b0, 37, -1);
        tx_start = 1'b0;
        idle_cycles("noqueue", 3 * N);

        for (int f = 0; f < 3; f++) run_frame("b2b00", 8'h00, 1'b1, -1, -1);
        tx_start = 1'b0;
        idle_cycles("after_b2b", 3);

        run_frame("abort0F", 8'h0F, 1'b0, -1, 45);
        idle_cycles("post_abort", 2 * N);
        run_frame("byte0F", 8'h0F, 1'b0, -1, -1);
        idle_cycles("after0F", 3);

        rst         = 1'b1;
        tx_start    = 1'b1;
        parallel_in = 8'hC3;
        tick();
        check("rst_wins", 0, 3'b100);
        rst      = 1'b0;
        tx_start = 1'b0;
        idle_cycles("rst_wins_idle", 5);

        run_frame("byte07", 8'h07, 1'b0, -1, -1);
        idle_cycles("after07", 2);
        run_frame("byte03", 8'h03, 1'b0, -1, -1);
        idle_cycles("after03", 2);

        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom_range(0, 255));
            run_frame("rand", r, 1'b0, -1, -1);
            idle_cycles("after_rand", 1 + k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
